// File: rtl/tdm_demux8_1.sv
// tdm_demux8_1: receive side of an 8:1 TDM slot stream.
// Samples one bit per EN strobe and locks to the SYNC marker on slot 0.
// Each completed frame is presented as a registered byte on Y with a
// one-cycle VALID pulse.
// Optional feature: define TDM_PARITY_EN to add a ninth slot carrying
// even parity over slots 0..7. A frame with a parity mismatch raises ERR.
module tdm_demux8_1 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic       D,
  input  logic       SYNC,
  output logic [7:0] Y,
  output logic [3:0] S,
  output logic       VALID,
  output logic       ERR
);

`ifdef TDM_PARITY_EN
  localparam int unsigned SW   = 4;  // slot index width, slots 0..8
  localparam int unsigned Last = 8;
  localparam int unsigned ShW  = 8;  // all data slots buffered before parity check
`else
  localparam int unsigned SW   = 3;  // slots 0..7, so S[3] is tied to 0
  localparam int unsigned Last = 7;
  localparam int unsigned ShW  = 7;  // slot 7 goes straight from D into Y
`endif

  typedef enum logic [0:0] {StHunt, StLock} state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [ShW-1:0]   shadow_q, shadow_d;
  logic [7:0]       y_q, y_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  // Next-state logic: state advances only on strobes; pulses default low.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    shadow_d = shadow_q;
    y_d      = y_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    if (EN) begin
      unique case (state_q)
        StHunt: begin
          if (SYNC) begin
            shadow_d[0] = D;
            s_d         = SW'(1);
            state_d     = StLock;
          end
        end
        StLock: begin
          if (s_q == '0) begin
            if (SYNC) begin
              shadow_d[0] = D;
              s_d         = SW'(1);
            end else begin
              // Lost the marker: drop the frame and re-acquire.
              err_d   = 1'b1;
              s_d     = '0;
              state_d = StHunt;
            end
          end else if (SYNC) begin
            // Early sync: this strobe becomes slot 0 of a new frame.
            err_d       = 1'b1;
            shadow_d[0] = D;
            s_d         = SW'(1);
          end else if (s_q < SW'(Last)) begin
            shadow_d[s_q[2:0]] = D;
            s_d                = s_q + SW'(1);
          end else begin
            s_d = '0;
`ifdef TDM_PARITY_EN
            if ((^shadow_q) == D) begin
              y_d     = shadow_q;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
`else
            y_d     = {D, shadow_q};
            valid_d = 1'b1;
`endif
          end
        end
        default: begin
          state_d = StHunt;
          s_d     = '0;
        end
      endcase
    end
  end

  // State registers with synchronous active-high reset; reset beats a strobe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StHunt;
      s_q      <= '0;
      shadow_q <= '0;
      y_q      <= 8'h00;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign Y     = y_q;
  assign S     = 4'(s_q);
  assign VALID = valid_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_tdm_demux8_1.sv
// Self-checking bench for tdm_demux8_1: table of frames plus hand-written
// sequences for sync loss, early sync, reset mid-frame and parity.
module tb_tdm_demux8_1;

  logic       CLK;
  logic       RESET;
  logic       EN;
  logic       D;
  logic       SYNC;
  logic [7:0] Y;
  logic [3:0] S;
  logic       VALID;
  logic       ERR;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_y;

  typedef struct {
    logic [7:0] data;
    int         gap;
    logic [7:0] exp_y;
  } vec_t;

  vec_t vecs[6];

  tdm_demux8_1 dut (
    .CLK  (CLK),
    .RESET(RESET),
    .EN   (EN),
    .D    (D),
    .SYNC (SYNC),
    .Y    (Y),
    .S    (S),
    .VALID(VALID),
    .ERR  (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // One clock: inputs change on the falling edge, outputs are read 1 after the rising edge.
  task automatic strobe(input logic en, input logic d, input logic sync);
    @(negedge CLK);
    EN   = en;
    D    = d;
    SYNC = sync;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_slots(input logic [7:0] data, input int lo, input int hi, input int gap);
    for (int k = lo; k <= hi; k++) begin
      for (int g = 0; g < gap; g++) strobe(1'b0, 1'($urandom), 1'($urandom));
      strobe(1'b1, data[k], k == 0);
    end
  endtask

  // Sends slots lo..end of a frame; queues the expected byte if it should complete.
  task automatic send_frame_from(input logic [7:0] data, input int lo, input int gap,
                                 input logic par_flip);
`ifdef TDM_PARITY_EN
    send_slots(data, lo, 7, gap);
    for (int g = 0; g < gap; g++) strobe(1'b0, 1'($urandom), 1'($urandom));
    if (!par_flip) begin
      exp_q.push_back(data);
      last_y = data;
    end
    strobe(1'b1, (^data) ^ par_flip, 1'b0);
`else
    send_slots(data, lo, 6, gap);
    for (int g = 0; g < gap; g++) strobe(1'b0, 1'($urandom), 1'($urandom));
    exp_q.push_back(data);
    last_y = data;
    strobe(1'b1, data[7], 1'b0);
`endif
  endtask

  // Scoreboard: every VALID pulse must match the oldest queued frame.
  always @(negedge CLK) begin
    if (VALID === 1'b1) begin
      if (exp_q.size() == 0) check("valid_unexpected", 32'(VALID), 32'h0);
      else check("sb_y", 32'(Y), 32'(exp_q.pop_front()));
      if (ERR === 1'b1) check("valid_err_excl", 32'(ERR), 32'h0);
    end
  end

  initial begin
    logic a, b, c, d_, e, f, g, h;
    logic [7:0] mux_in;
    logic [2:0] sel;

    vecs[0] = '{data: 8'hA5, gap: 0, exp_y: 8'hA5};
    vecs[1] = '{data: 8'h00, gap: 0, exp_y: 8'h00};
    vecs[2] = '{data: 8'hFF, gap: 1, exp_y: 8'hFF};
    vecs[3] = '{data: 8'h3C, gap: 2, exp_y: 8'h3C};
    vecs[4] = '{data: 8'h81, gap: 0, exp_y: 8'h81};
    vecs[5] = '{data: 8'h5A, gap: 3, exp_y: 8'h5A};

    RESET  = 1'b1;
    EN     = 1'b0;
    D      = 1'b0;
    SYNC   = 1'b0;
    last_y = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_y", 32'(Y), 32'h00);
    check("rst_s", 32'(S), 32'h0);
    check("rst_valid", 32'(VALID), 32'h0);
    check("rst_err", 32'(ERR), 32'h0);
    @(negedge CLK);
    RESET = 1'b0;

    // Table-driven frames, back-to-back or with sparse strobes.
    foreach (vecs[i]) begin
      send_frame_from(vecs[i].data, 0, vecs[i].gap, 1'b0);
      check("tbl_valid", 32'(VALID), 32'h1);
      check("tbl_y", 32'(Y), 32'(vecs[i].exp_y));
      check("tbl_err", 32'(ERR), 32'h0);
      check("tbl_s_wrap", 32'(S), 32'h0);
      strobe(1'b0, 1'b1, 1'b1);
      check("tbl_valid_clr", 32'(VALID), 32'h0);
      check("tbl_y_hold", 32'(Y), 32'(vecs[i].exp_y));
    end

`ifndef TDM_PARITY_EN
    // Stream from a MUX8_1 with A..H = 1,0,1,1,0,0,1,0 and a free-running select.
    a = 1; b = 0; c = 1; d_ = 1; e = 0; f = 0; g = 1; h = 0;
    mux_in = {h, g, f, e, d_, c, b, a};
    sel = 3'd0;
    for (int n = 0; n < 24; n++) begin
      if (sel == 3'd7) begin
        exp_q.push_back(8'b01001101);
        last_y = 8'b01001101;
      end
      strobe(1'b1, mux_in[sel], sel == 3'd0);
      sel = sel + 3'd1;
    end
    check("mux_y", 32'(Y), 32'h4D);
    check("mux_valid", 32'(VALID), 32'h1);
`endif

    // Early sync at S=4 during 8'h3C; that strobe starts frame 8'hC3.
    send_slots(8'h3C, 0, 3, 0);
    check("early_s_pre", 32'(S), 32'h4);
    strobe(1'b1, 1'b1, 1'b1);
    check("early_err", 32'(ERR), 32'h1);
    check("early_s", 32'(S), 32'h1);
    check("early_y_hold", 32'(Y), 32'(last_y));
    check("early_novalid", 32'(VALID), 32'h0);
    send_frame_from(8'hC3, 1, 0, 1'b0);
    check("early_next_y", 32'(Y), 32'hC3);
    check("early_next_err", 32'(ERR), 32'h0);

    // Missing sync on slot 0 after a good frame.
    strobe(1'b1, 1'b1, 1'b0);
    check("nosync_err", 32'(ERR), 32'h1);
    check("nosync_s", 32'(S), 32'h0);
    check("nosync_y", 32'(Y), 32'(last_y));
    for (int n = 0; n < 5; n++) begin
      strobe(1'b1, 1'($urandom), 1'b0);
      check("hunt_err", 32'(ERR), 32'h0);
      check("hunt_s", 32'(S), 32'h0);
      check("hunt_y", 32'(Y), 32'(last_y));
    end
    send_frame_from(8'h69, 0, 0, 1'b0);
    check("relock_y", 32'(Y), 32'h69);

    // Reset at S=5 with a strobe on the same edge.
    send_slots(8'h5A, 0, 4, 0);
    check("rst_mid_s_pre", 32'(S), 32'h5);
    @(negedge CLK);
    RESET = 1'b1;
    EN    = 1'b1;
    D     = 1'b1;
    SYNC  = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_mid_y", 32'(Y), 32'h00);
    check("rst_mid_s", 32'(S), 32'h0);
    check("rst_mid_valid", 32'(VALID), 32'h0);
    last_y = 8'h00;
    @(negedge CLK);
    RESET = 1'b0;
    EN    = 1'b0;
    strobe(1'b1, 1'b1, 1'b0);
    check("rst_rehunt_s", 32'(S), 32'h0);
    send_frame_from(8'h96, 0, 0, 1'b0);
    check("rst_after_y", 32'(Y), 32'h96);

`ifdef TDM_PARITY_EN
    send_frame_from(8'h07, 0, 0, 1'b0);
    check("par_ok_valid", 32'(VALID), 32'h1);
    check("par_ok_y", 32'(Y), 32'h07);
    send_frame_from(8'h07, 0, 0, 1'b1);
    check("par_bad_err", 32'(ERR), 32'h1);
    check("par_bad_valid", 32'(VALID), 32'h0);
    check("par_bad_y", 32'(Y), 32'h07);
    check("par_bad_s", 32'(S), 32'h0);
    send_frame_from(8'hE1, 0, 1, 1'b0);
    check("par_next_y", 32'(Y), 32'hE1);
`endif

    repeat (2) strobe(1'b0, 1'b0, 1'b0);
    check("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
